map_ss_seq: RTL and testbench

- Save-state sequencer for the mapper save-state port (ss_act/ss_we/ss_addr/ss_rdat, with write data on the CPU data lines).
- On host command it walks mapper register indices 0..REG_CNT-1, then index 127 (map_idx).
- Save: streams register bytes out to the host.
- Restore: streams host bytes into the mapper, with strobes stretched so the mapper's negedge-m2 capture logic sees them.

---
 rtl/map_ss_seq.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_map_ss_seq.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_ss_seq.sv
// map_ss_seq: save-state sequencer for the mapper save-state port.
// Optional stream checksum byte enabled by defining SS_SEQ_CHK_EN.
module map_ss_seq #(
  parameter int REG_CNT = 10,
  parameter int STB_CYC = 4,
  parameter int RD_LAT  = 2,
  parameter int SETTLE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic       din_rdy
);

  localparam logic [7:0] MAP_IDX = 8'd127;
  localparam logic [7:0] LAST_REG = 8'(REG_CNT - 1);
  localparam logic [7:0] SET_END = 8'(SETTLE - 1);
  localparam logic [7:0] RD_END = 8'(RD_LAT - 1);
  localparam logic [7:0] STB_END = 8'(STB_CYC);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RD_WAIT,
    RD_OUT,
    WR_IN,
    WR_STB,
    NEXT,
    RELEASE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d;
  logic       mode_q, mode_d;
  logic       err_q, err_d;
  logic       abrt_q, abrt_d;
  logic       act_q, act_d;
  logic       we_q, we_d;
  logic       done_q, done_d;
  logic [7:0] dout_q, dout_d;
  logic       vld_q, vld_d;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] cnt_inc;
  logic       last;

`ifdef SS_SEQ_CHK_EN
  logic [7:0] sum_q, sum_d;
  logic       chk_q, chk_d;
  logic [7:0] sum_in;

  assign sum_in = sum_q + din;
  assign last = (idx_q == MAP_IDX) && chk_q;
`else
  assign last = (idx_q == MAP_IDX);
`endif

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    mode_d = mode_q;
    err_d = err_q;
    abrt_d = abrt_q;
    act_d = act_q;
    we_d = we_q;
    done_d = 1'b0;
    dout_d = dout_q;
    vld_d = vld_q;
    wdat_d = wdat_q;
`ifdef SS_SEQ_CHK_EN
    sum_d = sum_q;
    chk_d = chk_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          mode_d = mode;
          err_d = 1'b0;
          abrt_d = 1'b0;
          act_d = 1'b1;
          idx_d = 8'd0;
          cnt_d = 8'd0;
`ifdef SS_SEQ_CHK_EN
          sum_d = 8'd0;
          chk_d = 1'b0;
`endif
        end
      end
      ARM: begin
        if (cnt_q == SET_END) begin
          cnt_d = 8'd0;
          state_d = mode_q ? WR_IN : RD_WAIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RD_WAIT: begin
        if (cnt_q == RD_END) begin
          cnt_d = 8'd0;
          if (mode_q) begin
            // restore: verify map_idx instead of writing it
            if (ss_rdat != wdat_q) begin
              err_d = 1'b1;
            end
            state_d = NEXT;
          end else begin
            dout_d = ss_rdat;
            vld_d = 1'b1;
`ifdef SS_SEQ_CHK_EN
            sum_d = sum_q + ss_rdat;
`endif
            state_d = RD_OUT;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RD_OUT: begin
        if (dout_rdy) begin
          vld_d = 1'b0;
          state_d = NEXT;
        end
      end
      WR_IN: begin
        if (din_vld) begin
          wdat_d = din;
          cnt_d = 8'd0;
`ifdef SS_SEQ_CHK_EN
          sum_d = sum_in;
          if (chk_q) begin
            if (sum_in != 8'd0) begin
              err_d = 1'b1;
            end
            state_d = NEXT;
          end else
`endif
          if (idx_q == MAP_IDX) begin
            state_d = RD_WAIT;
          end else begin
            state_d = WR_STB;
          end
        end
      end
      WR_STB: begin
        // first cycle is data setup, then STB_CYC strobe cycles
        if (cnt_q == STB_END) begin
          we_d = 1'b0;
          cnt_d = 8'd0;
          state_d = NEXT;
        end else begin
          we_d = 1'b1;
          cnt_d = cnt_inc;
        end
      end
      NEXT: begin
        cnt_d = 8'd0;
        if (last) begin
          state_d = RELEASE;
        end
`ifdef SS_SEQ_CHK_EN
        else if (idx_q == MAP_IDX) begin
          chk_d = 1'b1;
          if (mode_q) begin
            state_d = WR_IN;
          end else begin
            dout_d = ~sum_q + 8'd1;
            vld_d = 1'b1;
            state_d = RD_OUT;
          end
        end
`endif
        else begin
          if (idx_q == LAST_REG) begin
            idx_d = MAP_IDX;
          end else begin
            idx_d = idx_q + 8'd1;
          end
          state_d = mode_q ? WR_IN : RD_WAIT;
        end
      end
      RELEASE: begin
        we_d = 1'b0;
        if (cnt_q == SET_END) begin
          act_d = 1'b0;
          done_d = ~abrt_q;
          cnt_d = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // abort overrides any active state
    if (abort && (state_q != IDLE)) begin
      err_d = 1'b1;
      abrt_d = 1'b1;
      we_d = 1'b0;
      vld_d = 1'b0;
      done_d = 1'b0;
      if (state_q != RELEASE) begin
        state_d = RELEASE;
        cnt_d = 8'd0;
      end
    end
  end

  // State and datapath registers, async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      idx_q <= 8'd0;
      mode_q <= 1'b0;
      err_q <= 1'b0;
      abrt_q <= 1'b0;
      act_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= 8'd0;
      vld_q <= 1'b0;
      wdat_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      err_q <= err_d;
      abrt_q <= abrt_d;
      act_q <= act_d;
      we_q <= we_d;
      done_q <= done_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
      wdat_q <= wdat_d;
    end
  end

`ifdef SS_SEQ_CHK_EN
  // Running stream sum for the checksum byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 8'd0;
      chk_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      chk_q <= chk_d;
    end
  end
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err = err_q;
  assign ss_act = act_q;
  assign ss_we = we_q;
  assign ss_addr = idx_q;
  assign ss_wdat = wdat_q;
  assign dout = dout_q;
  assign dout_vld = vld_q & ~abort;
  assign din_rdy = (state_q == WR_IN) & ~abort;

endmodule

// File: tb/tb_map_ss_seq.sv
// tb_map_ss_seq: scoreboard bench for map_ss_seq.
// Directed save/restore/abort vectors with queued expectations.
module tb_map_ss_seq;

`ifdef SS_SEQ_CHK_EN
  localparam int NB = 12;
`else
  localparam int NB = 11;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [7:0] dout;
  logic       dout_vld;
  logic       dout_rdy = 1'b1;
  logic [7:0] din = 8'd0;
  logic       din_vld = 1'b0;
  logic       din_rdy;

  int n_tests = 0;
  int n_fail = 0;

  logic [7:0] exp_dout[$];
  logic [7:0] exp_wa[$];
  logic [7:0] exp_wd[$];
  logic [7:0] din_q[$];

  int beats = 0;
  int rcvd = 0;
  int we_pulses = 0;
  int done_cnt = 0;
  int wr_len_exp = 4;
  bit stall_en = 0;
  int stall_n = 0;

  map_ss_seq dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .abort(abort),
    .busy(busy),
    .done(done),
    .err(err),
    .ss_act(ss_act),
    .ss_we(ss_we),
    .ss_addr(ss_addr),
    .ss_wdat(ss_wdat),
    .ss_rdat(ss_rdat),
    .dout(dout),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .din(din),
    .din_vld(din_vld),
    .din_rdy(din_rdy)
  );

  always #5 clk = ~clk;

  // mapper read-back model: regs hold index+0x10, map_idx is 0x70
  assign ss_rdat = (ss_addr == 8'd127) ? 8'h70 : ss_addr + 8'h10;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // save stream: ready driver and scoreboard pop
  always @(negedge clk) begin
    if (stall_en && dout_vld && dout == 8'h13 && stall_n < 5) begin
      dout_rdy = 1'b0;
      stall_n++;
      check("stall_addr", {24'd0, ss_addr}, 32'd3);
    end else begin
      dout_rdy = 1'b1;
    end
    if (!rst && dout_vld && dout_rdy) begin
      beats++;
      if (exp_dout.size() == 0) begin
        check("dout_unexpected", {24'd0, dout}, 32'hFFFF);
      end else begin
        check("dout", {24'd0, dout}, {24'd0, exp_dout.pop_front()});
      end
    end
  end

  // restore stream driver
  bit acc = 0;
  always @(negedge clk) begin
    if (acc && din_q.size() > 0) begin
      void'(din_q.pop_front());
      rcvd++;
    end
    if (din_q.size() > 0) begin
      din_vld = 1'b1;
      din = din_q[0];
    end else begin
      din_vld = 1'b0;
    end
    acc = din_vld && din_rdy;
  end

  // write strobe monitor
  logic       we_prev = 1'b0;
  logic [15:0] prev_aw = 16'd0;
  logic [15:0] hold_aw = 16'd0;
  int wlen = 0;
  always @(negedge clk) begin
    if (ss_we && !we_prev) begin
      wlen = 1;
      hold_aw = {ss_addr, ss_wdat};
      check("we_setup", {16'd0, prev_aw}, {16'd0, hold_aw});
      if (exp_wa.size() == 0) begin
        check("wr_unexpected", {24'd0, ss_addr}, 32'hFFFF);
      end else begin
        check("wr_addr", {24'd0, ss_addr}, {24'd0, exp_wa.pop_front()});
        check("wr_data", {24'd0, ss_wdat}, {24'd0, exp_wd.pop_front()});
      end
    end else if (ss_we) begin
      wlen++;
      check("we_stable", {16'd0, ss_addr, ss_wdat}, {16'd0, hold_aw});
    end else if (we_prev && !rst) begin
      we_pulses++;
      check("we_len", wlen, wr_len_exp);
      check("we_hold", {16'd0, ss_addr, ss_wdat}, {16'd0, hold_aw});
    end
    we_prev = ss_we;
    prev_aw = {ss_addr, ss_wdat};
  end

  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
  end

  task automatic push_save();
    for (int i = 0; i < 10; i++) begin
      exp_dout.push_back(8'h10 + 8'(i));
    end
    exp_dout.push_back(8'h70);
`ifdef SS_SEQ_CHK_EN
    exp_dout.push_back(8'hC3);
`endif
  endtask

  task automatic push_restore(input logic [7:0] last,
                              input logic [7:0] ck,
                              input int nwr);
    for (int i = 0; i < 10; i++) begin
      din_q.push_back(8'hA0 + 8'(i));
    end
    din_q.push_back(last);
`ifdef SS_SEQ_CHK_EN
    din_q.push_back(ck);
`else
    if (ck == 8'hFF) din_q.push_back(ck);
`endif
    for (int i = 0; i < nwr; i++) begin
      exp_wa.push_back(8'(i));
      exp_wd.push_back(8'hA0 + 8'(i));
    end
  endtask

  task automatic start_op(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_timeout"}, (k >= 3000) ? 32'd1 : 32'd0, 32'd0);
    @(negedge clk);
  endtask

  int d0, w0, b0, r0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_act", {31'd0, ss_act}, 32'd0);
    check("rst_we", {31'd0, ss_we}, 32'd0);
    check("rst_addr", {24'd0, ss_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out", {28'd0, dout_vld, din_rdy, done, err}, 32'd0);

    // plain save
    push_save();
    d0 = done_cnt; w0 = we_pulses; b0 = beats;
    start_op(1'b0);
    check("save_busy", {31'd0, busy}, 32'd1);
    check("save_act", {31'd0, ss_act}, 32'd1);
    wait_idle("save");
    check("save_done", done_cnt - d0, 1);
    check("save_beats", beats - b0, NB);
    check("save_no_we", we_pulses - w0, 0);
    check("save_err", {31'd0, err}, 32'd0);
    check("save_left", exp_dout.size(), 0);
    check("save_act_off", {31'd0, ss_act}, 32'd0);

    // save with back-pressure on beat 3
    push_save();
    d0 = done_cnt; b0 = beats;
    stall_en = 1; stall_n = 0;
    start_op(1'b0);
    wait_idle("stall");
    stall_en = 0;
    check("stall_cycles", stall_n, 5);
    check("stall_beats", beats - b0, NB);
    check("stall_left", exp_dout.size(), 0);
    check("stall_done", done_cnt - d0, 1);

    // restore, map_idx matches
    push_restore(8'h70, 8'h23, 10);
    d0 = done_cnt; w0 = we_pulses; r0 = rcvd;
    start_op(1'b1);
    wait_idle("rest");
    check("rest_we", we_pulses - w0, 10);
    check("rest_rcvd", rcvd - r0, NB);
    check("rest_err", {31'd0, err}, 32'd0);
    check("rest_done", done_cnt - d0, 1);
    check("rest_left", exp_wa.size(), 0);

    // restore, map_idx mismatch
    push_restore(8'h55, 8'h3E, 10);
    d0 = done_cnt; w0 = we_pulses;
    start_op(1'b1);
    wait_idle("bad");
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_done", done_cnt - d0, 1);
    check("bad_we", we_pulses - w0, 10);
    repeat (3) @(negedge clk);
    check("bad_sticky", {31'd0, err}, 32'd1);

    // next start clears err
    push_save();
    d0 = done_cnt;
    start_op(1'b0);
    check("clr_err", {31'd0, err}, 32'd0);
    wait_idle("clr");
    check("clr_done", done_cnt - d0, 1);
    check("clr_left", exp_dout.size(), 0);

    // abort in the 2nd strobe cycle at index 4
    push_restore(8'h70, 8'h23, 5);
    d0 = done_cnt; w0 = we_pulses;
    start_op(1'b1);
    begin
      int k = 0;
      while (!(ss_we && ss_addr == 8'd4) && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check("abrt_timeout", (k >= 2000) ? 32'd1 : 32'd0, 32'd0);
    end
    @(negedge clk);
    wr_len_exp = 2;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abrt_we", {31'd0, ss_we}, 32'd0);
    check("abrt_act1", {31'd0, ss_act}, 32'd1);
    check("abrt_rdy", {31'd0, din_rdy}, 32'd0);
    @(negedge clk);
    check("abrt_act2", {31'd0, ss_act}, 32'd1);
    @(negedge clk);
    check("abrt_act3", {31'd0, ss_act}, 32'd1);
    @(negedge clk);
    check("abrt_act_off", {31'd0, ss_act}, 32'd0);
    check("abrt_busy", {31'd0, busy}, 32'd0);
    check("abrt_err", {31'd0, err}, 32'd1);
    din_q.delete();
    @(negedge clk);
    wr_len_exp = 4;
    check("abrt_done", done_cnt - d0, 0);
    check("abrt_we_n", we_pulses - w0, 5);
    check("abrt_left", exp_wa.size(), 0);

`ifdef SS_SEQ_CHK_EN
    // restore with corrupted checksum byte
    push_restore(8'h70, 8'h24, 10);
    d0 = done_cnt; w0 = we_pulses;
    start_op(1'b1);
    wait_idle("ck");
    check("ck_err", {31'd0, err}, 32'd1);
    check("ck_done", done_cnt - d0, 1);
    check("ck_we", we_pulses - w0, 10);
`endif

    // reset in the middle of an operation
    start_op(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_act", {31'd0, ss_act}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_dout.delete();
    @(negedge clk);
    check("mid_rst_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
